// File: rtl/mem_bus_if.sv
// External data-bus signal bundle: valid/ready request channel with byte enables.
// The adapter drives the request side through the master modport.
interface mem_bus_if;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/mem_bus.sv
// Data-memory bus adapter: turns memory-stage load/store strobes into one valid/ready
// bus transfer with lane steering, load extension, misalignment and timeout errors.
module mem_bus #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_out,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] mem_in,
  output logic        stall,
  output logic        bus_err,
  mem_bus_if.master   bus
);

  typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [31:0] rdata_q;

  logic        req;
  logic        misalign;
  logic        accept;
  logic        capture;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign req = mem_ren | mem_wen;

  // Size 3 decodes as word everywhere, so test size[1] rather than size == 2.
  always_comb begin
    misalign   = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = mem_out;
    if (mem_size == 2'd0) begin
      be_calc    = 4'b0001 << mem_addr[1:0];
      wdata_calc = {4{mem_out[7:0]}};
    end else if (mem_size == 2'd1) begin
      misalign   = mem_addr[0];
      be_calc    = mem_addr[1] ? 4'b1100 : 4'b0011;
      wdata_calc = {2{mem_out[15:0]}};
    end else begin
      misalign   = (mem_addr[1:0] != 2'b00);
    end
  end

  assign shifted = bus.bus_rdata >> {lane_q, 3'b000};

  always_comb begin
    load_ext = bus.bus_rdata;
    if (size_q == 2'd0) begin
      load_ext = uns_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    end else if (size_q == 2'd1) begin
      load_ext = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (misalign) begin
            state_d = StErr;
          end else begin
            state_d = StReq;
            accept  = 1'b1;
            cnt_d   = 16'd0;
          end
        end
      end
      StReq: begin
        if (bus.bus_ready) begin
          state_d = StDone;
          capture = 1'b1;
        end else if (cnt_q == 16'(TIMEOUT)) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      lane_q  <= 2'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= mem_wen;
        addr_q  <= {mem_addr[31:2], 2'b00};
        wdata_q <= wdata_calc;
        be_q    <= be_calc;
        size_q  <= mem_size;
        uns_q   <= mem_unsigned;
        lane_q  <= mem_addr[1:0];
      end
      if (capture) begin
        rdata_q <= we_q ? 32'd0 : load_ext;
      end
    end
  end

  assign bus.bus_valid = (state_q == StReq);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_be    = be_q;

  assign mem_in  = (state_q == StDone) ? rdata_q : 32'd0;
  assign bus_err = (state_q == StErr);
  // Gated by rst so a request held during reset cannot raise stall.
  assign stall   = rst & ((state_q == StReq) | ((state_q == StIdle) & req));

endmodule

// File: tb/tb_mem_bus.sv
// Bench for mem_bus: table-driven accesses with a result scoreboard, plus timeout
// and mid-transaction reset sequences.
module tb_mem_bus;

  logic        clk;
  logic        rst;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_out;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_in;
  logic        stall;
  logic        bus_err;

  mem_bus_if bif ();

  mem_bus #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_ren      (mem_ren),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_out      (mem_out),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .mem_in       (mem_in),
    .stall        (stall),
    .bus_err      (bus_err),
    .bus          (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    int          waits;
    logic        err;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] min;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] min;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests  = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic wen, input logic ren, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size,
                              input logic uns, input logic [31:0] rdata, input int waits,
                              input logic err, input logic [3:0] be,
                              input logic [31:0] baddr, input logic [31:0] bwdata,
                              input logic [31:0] min);
    vec_t v;
    v.wen = wen; v.ren = ren; v.addr = addr; v.wdata = wdata; v.size = size;
    v.uns = uns; v.rdata = rdata; v.waits = waits; v.err = err; v.be = be;
    v.baddr = baddr; v.bwdata = bwdata; v.min = min;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      errors++;
      $display("FAIL %s_sb: got empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_err"}, {31'd0, bus_err}, {31'd0, e.err});
      chk({tag, "_mem_in"}, mem_in, e.min);
    end
  endtask

  task automatic drop_req();
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    bif.bus_ready = 1'b0;
  endtask

  task automatic drive_req(input vec_t v);
    mem_wen      = v.wen;
    mem_ren      = v.ren;
    mem_addr     = v.addr;
    mem_out      = v.wdata;
    mem_size     = v.size;
    mem_unsigned = v.uns;
    bif.bus_ready = 1'b0;
  endtask

  task automatic do_access(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    drive_req(v);
    e.err = v.err;
    e.min = v.min;
    sb.push_back(e);
    #1 chk({tag, "_stall_c0"}, {31'd0, stall}, 32'd1);
    @(negedge clk);
    if (v.err) begin
      chk({tag, "_valid_c1"}, {31'd0, bif.bus_valid}, 32'd0);
      chk({tag, "_stall_c1"}, {31'd0, stall}, 32'd0);
      pop_check(tag);
      drop_req();
    end else begin
      chk({tag, "_valid_c1"}, {31'd0, bif.bus_valid}, 32'd1);
      chk({tag, "_stall_c1"}, {31'd0, stall}, 32'd1);
      chk({tag, "_we"}, {31'd0, bif.bus_we}, {31'd0, v.wen});
      chk({tag, "_be"}, {28'd0, bif.bus_be}, {28'd0, v.be});
      chk({tag, "_addr"}, bif.bus_addr, v.baddr);
      chk({tag, "_wdata"}, bif.bus_wdata, v.bwdata);
      for (int i = 0; i < v.waits; i++) begin
        @(negedge clk);
        chk({tag, "_valid_wait"}, {31'd0, bif.bus_valid}, 32'd1);
        chk({tag, "_addr_hold"}, bif.bus_addr, v.baddr);
      end
      bif.bus_ready = 1'b1;
      bif.bus_rdata = v.rdata;
      @(negedge clk);
      bif.bus_ready = 1'b0;
      bif.bus_rdata = 32'h5A5A_5A5A;
      chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
      chk({tag, "_valid_done"}, {31'd0, bif.bus_valid}, 32'd0);
      pop_check(tag);
      drop_req();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   vcnt;
    bit   seen;

    rst = 1'b0;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = 32'd0; mem_out = 32'd0;
    mem_size = 2'd0; mem_unsigned = 1'b0;
    bif.bus_ready = 1'b0; bif.bus_rdata = 32'd0;

    //       wen ren addr       wdata          sz uns rdata          w err be       baddr
    vecs.push_back(mk(0, 1, 32'h100, 32'h0,        2, 0, 32'hDEADBEEF, 0, 0, 4'hF, 32'h100,
                      32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 32'h103, 32'h0,        0, 0, 32'h80123456, 0, 0, 4'h8, 32'h100,
                      32'h0,        32'hFFFFFF80));
    vecs.push_back(mk(0, 1, 32'h103, 32'h0,        0, 1, 32'h80123456, 1, 0, 4'h8, 32'h100,
                      32'h0,        32'h00000080));
    vecs.push_back(mk(1, 0, 32'h202, 32'h1234ABCD, 1, 0, 32'hFFFFFFFF, 0, 0, 4'hC, 32'h200,
                      32'hABCDABCD, 32'h0));
    vecs.push_back(mk(1, 1, 32'h202, 32'h1234ABCD, 1, 0, 32'hFFFFFFFF, 2, 0, 4'hC, 32'h200,
                      32'hABCDABCD, 32'h0));
    vecs.push_back(mk(0, 1, 32'h101, 32'h0,        2, 0, 32'h0,        0, 1, 4'h0, 32'h0,
                      32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 32'h002, 32'h0,        1, 0, 32'h80010000, 0, 0, 4'hC, 32'h000,
                      32'h0,        32'hFFFF8001));
    vecs.push_back(mk(1, 0, 32'h003, 32'h0,        1, 0, 32'h0,        0, 1, 4'h0, 32'h0,
                      32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 32'h011, 32'h000000A5, 0, 0, 32'h0,        1, 0, 4'h2, 32'h010,
                      32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(0, 1, 32'h020, 32'h0,        3, 0, 32'h12345678, 0, 0, 4'hF, 32'h020,
                      32'h0,        32'h12345678));
    vecs.push_back(mk(0, 1, 32'h001, 32'h0,        0, 0, 32'h0000FF00, 0, 0, 4'h2, 32'h000,
                      32'h0,        32'hFFFFFFFF));
    vecs.push_back(mk(0, 1, 32'h000, 32'h0,        1, 1, 32'hFFFF8765, 3, 0, 4'h3, 32'h000,
                      32'h0,        32'h00008765));
    vecs.push_back(mk(1, 0, 32'h044, 32'h89ABCDEF, 2, 0, 32'h0,        0, 0, 4'hF, 32'h044,
                      32'h89ABCDEF, 32'h0));
    vecs.push_back(mk(0, 1, 32'h00E, 32'h0,        0, 1, 32'h00AB0000, 0, 0, 4'h4, 32'h00C,
                      32'h0,        32'h000000AB));
    vecs.push_back(mk(0, 1, 32'h106, 32'h0,        2, 0, 32'h0,        0, 1, 4'h0, 32'h0,
                      32'h0,        32'h0));

    #2;
    chk("rst_valid", {31'd0, bif.bus_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);
    chk("rst_mem_in", mem_in, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) do_access(vecs[i], $sformatf("vec%0d", i));

    // Timeout: ready never rises, valid should hold for TIMEOUT+1 cycles.
    v = mk(0, 1, 32'h40, 32'h0, 2, 0, 32'h0, 0, 1, 4'hF, 32'h40, 32'h0, 32'h0);
    @(negedge clk);
    drive_req(v);
    sb.push_back('{err: 1'b1, min: 32'd0});
    vcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bif.bus_valid) vcnt++;
      if (bus_err) begin
        seen = 1'b1;
        chk("to_valid_in_err", {31'd0, bif.bus_valid}, 32'd0);
        chk("to_stall_in_err", {31'd0, stall}, 32'd0);
        pop_check("to");
        drop_req();
      end
    end
    chk("to_err_seen", {31'd0, seen}, 32'd1);
    chk("to_valid_cycles", 32'(vcnt), 32'd5);
    if (!seen) begin
      void'(sb.pop_front());
      drop_req();
    end
    @(negedge clk);
    chk("to_err_pulse_end", {31'd0, bus_err}, 32'd0);
    chk("to_idle_stall", {31'd0, stall}, 32'd0);
    do_access(mk(0, 1, 32'h80, 32'h0, 2, 0, 32'hCAFEBABE, 0, 0, 4'hF, 32'h80, 32'h0,
                 32'hCAFEBABE), "after_to");

    // Reset in the middle of a waiting store: outputs must clear before the next edge.
    v = mk(1, 1, 32'h300, 32'hCAFEF00D, 2, 0, 32'h0, 0, 0, 4'hF, 32'h300, 32'hCAFEF00D,
           32'h0);
    @(negedge clk);
    drive_req(v);
    @(negedge clk);
    chk("mr_valid_pre", {31'd0, bif.bus_valid}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mr_valid", {31'd0, bif.bus_valid}, 32'd0);
    chk("mr_we", {31'd0, bif.bus_we}, 32'd0);
    chk("mr_addr", bif.bus_addr, 32'd0);
    chk("mr_wdata", bif.bus_wdata, 32'd0);
    chk("mr_be", {28'd0, bif.bus_be}, 32'd0);
    chk("mr_mem_in", mem_in, 32'd0);
    chk("mr_err", {31'd0, bus_err}, 32'd0);
    chk("mr_stall", {31'd0, stall}, 32'd0);
    drop_req();
    @(negedge clk);
    rst = 1'b1;
    do_access(mk(0, 1, 32'h304, 32'h0, 1, 0, 32'h00007FFF, 0, 0, 4'h3, 32'h304, 32'h0,
                 32'h00007FFF), "after_rst");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
